// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - state, opcode and control-field encodings for mc_control
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    OC_ILL = 3'd0,
    OC_R   = 3'd1,
    OC_I   = 3'd2,
    OC_LD  = 3'd3,
    OC_ST  = 3'd4,
    OC_BR  = 3'd5,
    OC_JAL = 3'd6,
    OC_LUI = 3'd7
  } op_class_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;
  localparam logic [1:0] M2R_IMM = 2'b11;

  localparam logic [1:0] ALUOP_DEF = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_I   = 2'b10;
  localparam logic [1:0] ALUOP_R   = 2'b11;

  // Loads and stores are the only classes that visit MEM
  function automatic logic is_mem_op(input op_class_e c);
    return (c == OC_LD) || (c == OC_ST);
  endfunction

endpackage

// File: rtl/mc_control_if.sv
// rtl/mc_control_if.sv - controller <-> datapath/memory signal bundle
interface mc_control_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       br_taken;

  logic       pc_write;
  logic       pc_src;
  logic       ir_write;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       regwrite;
  logic       branch;
  logic       ALUsrc;
  logic       jal;
  logic       retire;
  logic       trap;
  logic [1:0] memtoreg;
  logic [1:0] ALUop;
  logic [2:0] state;

  // Controller side
  modport master (
    input  opcode, mem_ready, br_taken,
    output pc_write, pc_src, ir_write, iord, memread, memwrite, regwrite,
           branch, ALUsrc, jal, retire, trap, memtoreg, ALUop, state
  );

  // Datapath / memory side
  modport slave (
    output opcode, mem_ready, br_taken,
    input  pc_write, pc_src, ir_write, iord, memread, memwrite, regwrite,
           branch, ALUsrc, jal, retire, trap, memtoreg, ALUop, state
  );
endinterface

// File: rtl/mc_control_op_class.sv
// rtl/mc_control_op_class.sv - major-opcode to instruction-class decoder
module op_class
  import mc_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_e  cls
);

  // Map the 7-bit major opcode onto one of the supported classes
  always_comb begin
    cls = OC_ILL;
    case (opcode)
      OP_R:    cls = OC_R;
      OP_I:    cls = OC_I;
      OP_LD:   cls = OC_LD;
      OP_ST:   cls = OC_ST;
      OP_BR:   cls = OC_BR;
      OP_JAL:  cls = OC_JAL;
      OP_LUI:  cls = OC_LUI;
      default: cls = OC_ILL;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle RV32 control FSM with memory-wait timeout
module mc_control
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input logic          clk,
  input logic          rst,
  mc_control_if.master bus
);

  localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  op_class_e        op_cls;
  logic             waiting;

  logic       pc_write, pc_src, ir_write, iord, memread, memwrite, regwrite;
  logic       branch, alu_src, jal, retire, trap;
  logic [1:0] memtoreg, alu_op;

  // Take the live opcode in DECODE, otherwise keep the latched one
  always_comb begin
    op_d = op_q;
    if (state_q == ST_DECODE) op_d = bus.opcode;
  end

  // In DECODE this classifies the incoming opcode; later it classifies op_q
  op_class u_op_class (
    .opcode (op_d),
    .cls    (op_cls)
  );

  // Next-state selection plus the not-ready wait counter and its timeout
  always_comb begin
    state_d = state_q;
    waiting = 1'b0;
    case (state_q)
      ST_FETCH: begin
        waiting = 1'b1;
        if (bus.mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (op_cls)
          OC_LUI:  state_d = ST_WB;
          OC_ILL:  state_d = ST_TRAP;
          default: state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (op_cls)
          OC_LD, OC_ST:        state_d = ST_MEM;
          OC_R, OC_I, OC_JAL:  state_d = ST_WB;
          OC_BR:               state_d = ST_FETCH;
          default:             state_d = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        if (!is_mem_op(op_cls)) begin
          state_d = ST_TRAP;
        end else begin
          waiting = 1'b1;
          if (bus.mem_ready) state_d = (op_cls == OC_LD) ? ST_WB : ST_FETCH;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_TRAP;
    endcase

    // Ready wins over the timeout because the trap is only taken while not ready
    wait_cnt_d = '0;
    if (waiting && !bus.mem_ready) begin
      wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
      if ((MEM_TIMEOUT != 0) && (wait_cnt_d >= CNT_LIMIT)) state_d = ST_TRAP;
    end
    if (state_d != state_q) wait_cnt_d = '0;
  end

  // State, latched opcode and wait counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      op_q       <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Per-state control outputs; ready/branch-dependent ones are Mealy
  always_comb begin
    pc_write = 1'b0;
    pc_src   = 1'b0;
    ir_write = 1'b0;
    iord     = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    branch   = 1'b0;
    alu_src  = 1'b0;
    jal      = 1'b0;
    retire   = 1'b0;
    trap     = 1'b0;
    memtoreg = M2R_ALU;
    alu_op   = ALUOP_DEF;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          memread = 1'b1;
          if (bus.mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        ST_EXEC: begin
          case (op_cls)
            OC_R: alu_op = ALUOP_R;
            OC_I, OC_LD, OC_ST: begin
              alu_op  = ALUOP_I;
              alu_src = 1'b1;
            end
            OC_BR: begin
              alu_op   = ALUOP_BR;
              branch   = 1'b1;
              pc_src   = 1'b1;
              pc_write = bus.br_taken;
              retire   = 1'b1;
            end
            OC_JAL: begin
              alu_op   = ALUOP_DEF;
              branch   = 1'b1;
              jal      = 1'b1;
              pc_src   = 1'b1;
              pc_write = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          if (is_mem_op(op_cls)) begin
            iord     = 1'b1;
            memread  = (op_cls == OC_LD);
            memwrite = (op_cls == OC_ST);
            retire   = (op_cls == OC_ST) && bus.mem_ready;
          end
        end
        ST_WB: begin
          regwrite = 1'b1;
          retire   = 1'b1;
          case (op_cls)
            OC_LD:   memtoreg = M2R_MEM;
            OC_JAL:  memtoreg = M2R_PC4;
            OC_LUI:  memtoreg = M2R_IMM;
            default: memtoreg = M2R_ALU;
          endcase
        end
        ST_TRAP: trap = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.pc_write = pc_write;
  assign bus.pc_src   = pc_src;
  assign bus.ir_write = ir_write;
  assign bus.iord     = iord;
  assign bus.memread  = memread;
  assign bus.memwrite = memwrite;
  assign bus.regwrite = regwrite;
  assign bus.branch   = branch;
  assign bus.ALUsrc   = alu_src;
  assign bus.jal      = jal;
  assign bus.retire   = retire;
  assign bus.trap     = trap;
  assign bus.memtoreg = memtoreg;
  assign bus.ALUop    = alu_op;
  assign bus.state    = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - instruction-schedule checks of mc_control
module tb_mc_control;

  localparam int TIMEOUT = 15;
  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_LD  = 7'b0000011;
  localparam logic [6:0] T_ST  = 7'b0100011;
  localparam logic [6:0] T_BR  = 7'b1100011;
  localparam logic [6:0] T_JAL = 7'b1101111;
  localparam logic [6:0] T_LUI = 7'b0110111;

  typedef struct packed {
    logic [2:0] state;
    logic [1:0] memtoreg;
    logic [1:0] aluop;
    logic pc_write, pc_src, ir_write, iord, memread, memwrite, regwrite;
    logic branch, alusrc, jal, retire, trap;
  } out_t;

  typedef struct {
    out_t       o;
    logic [6:0] opc;
    logic       rdy;
    logic       br;
  } step_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  step_t sched[$];

  mc_control_if bus ();
  mc_control dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic legal(input logic [6:0] op);
    return op inside {T_R, T_I, T_LD, T_ST, T_BR, T_JAL, T_LUI};
  endfunction

  function automatic out_t blank(input logic [2:0] st);
    out_t o = '0;
    o.state = st;
    return o;
  endfunction

  function automatic logic [6:0] rnd_op();
    return 7'($urandom);
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom);
  endfunction

  function automatic void push(input out_t o, input logic [6:0] opc, input logic rdy, input logic br);
    step_t s;
    s.o = o; s.opc = opc; s.rdy = rdy; s.br = br;
    sched.push_back(s);
  endfunction

  function automatic void push_trap();
    out_t o = blank(3'd5);
    o.trap = 1'b1;
    for (int i = 0; i < 3; i++) push(o, rnd_op(), rnd_bit(), rnd_bit());
  endfunction

  function automatic out_t observe();
    out_t o;
    o.state = bus.state;       o.memtoreg = bus.memtoreg; o.aluop = bus.ALUop;
    o.pc_write = bus.pc_write; o.pc_src = bus.pc_src;     o.ir_write = bus.ir_write;
    o.iord = bus.iord;         o.memread = bus.memread;   o.memwrite = bus.memwrite;
    o.regwrite = bus.regwrite; o.branch = bus.branch;     o.alusrc = bus.ALUsrc;
    o.jal = bus.jal;           o.retire = bus.retire;     o.trap = bus.trap;
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected cycle-by-cycle schedule of one instruction, from its class and wait counts
  task automatic plan(input logic [6:0] op, input int fw, input int mw, input logic br,
                      output bit trapped);
    out_t o;
    trapped = 1'b0;
    for (int i = 0; i < fw && i < TIMEOUT; i++) begin
      o = blank(3'd0); o.memread = 1'b1;
      push(o, rnd_op(), 1'b0, rnd_bit());
    end
    if (fw >= TIMEOUT) begin push_trap(); trapped = 1'b1; return; end
    o = blank(3'd0); o.memread = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
    push(o, rnd_op(), 1'b1, rnd_bit());
    push(blank(3'd1), op, rnd_bit(), rnd_bit());
    if (!legal(op)) begin push_trap(); trapped = 1'b1; return; end
    if (op == T_LUI) begin
      o = blank(3'd4); o.regwrite = 1'b1; o.retire = 1'b1; o.memtoreg = 2'b11;
      push(o, rnd_op(), rnd_bit(), rnd_bit());
      return;
    end
    o = blank(3'd2);
    case (op)
      T_R:  o.aluop = 2'b11;
      T_BR: begin o.aluop = 2'b01; o.branch = 1'b1; o.pc_src = 1'b1; o.pc_write = br; o.retire = 1'b1; end
      T_JAL: begin o.aluop = 2'b00; o.branch = 1'b1; o.jal = 1'b1; o.pc_src = 1'b1; o.pc_write = 1'b1; end
      default: begin o.aluop = 2'b10; o.alusrc = 1'b1; end
    endcase
    push(o, rnd_op(), rnd_bit(), br);
    if (op == T_BR) return;
    if (op == T_LD || op == T_ST) begin
      o = blank(3'd3); o.iord = 1'b1;
      o.memread = (op == T_LD); o.memwrite = (op == T_ST);
      for (int i = 0; i < mw && i < TIMEOUT; i++) push(o, rnd_op(), 1'b0, rnd_bit());
      if (mw >= TIMEOUT) begin push_trap(); trapped = 1'b1; return; end
      o.retire = (op == T_ST);
      push(o, rnd_op(), 1'b1, rnd_bit());
      if (op == T_ST) return;
    end
    o = blank(3'd4); o.regwrite = 1'b1; o.retire = 1'b1;
    o.memtoreg = (op == T_LD) ? 2'b01 : (op == T_JAL) ? 2'b10 : 2'b00;
    push(o, rnd_op(), rnd_bit(), rnd_bit());
  endtask

  // Called #1 after a rising edge; each step is sampled on the falling edge
  task automatic run_steps(input string tag, input int limit, output int rcount);
    int n = 0;
    rcount = 0;
    while (sched.size() > 0 && n < limit) begin
      step_t s;
      out_t  obs;
      s = sched.pop_front();
      bus.opcode = s.opc; bus.mem_ready = s.rdy; bus.br_taken = s.br;
      #4;
      obs = observe();
      rcount += int'(obs.retire);
      check($sformatf("%s_c%0d", tag, n), 32'(obs), 32'(s.o));
      @(posedge clk); #1;
      n++;
    end
    sched.delete();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; bus.mem_ready = 1'b1; bus.br_taken = 1'b1; bus.opcode = rnd_op();
    #4;
    check(tag, 32'(observe()), 32'(out_t'('0)));
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic do_instr(input string tag, input logic [6:0] op, input int fw, input int mw,
                          input logic br);
    bit trapped;
    int rc;
    plan(op, fw, mw, br, trapped);
    run_steps(tag, 1000, rc);
    check({tag, "_retires"}, 32'(rc), trapped ? 32'd0 : 32'd1);
    if (trapped) do_reset({tag, "_rst"});
  endtask

  initial begin
    bit   tr;
    int   rc;
    logic [6:0] op;
    logic [6:0] legal_ops [7] = '{T_R, T_I, T_LD, T_ST, T_BR, T_JAL, T_LUI};

    bus.opcode = '0; bus.mem_ready = 1'b0; bus.br_taken = 1'b0;
    @(posedge clk); #1;
    do_reset("reset_idle");

    do_instr("r_add",     T_R,   0, 0, 1'b0);
    do_instr("load_w3",   T_LD,  0, 3, 1'b0);
    do_instr("br_nt",     T_BR,  0, 0, 1'b0);
    do_instr("br_t",      T_BR,  0, 0, 1'b1);
    do_instr("jal",       T_JAL, 0, 0, 1'b0);
    do_instr("lui",       T_LUI, 0, 0, 1'b0);
    do_instr("store_w2",  T_ST,  0, 2, 1'b0);
    do_instr("itype_fw2", T_I,   2, 0, 1'b0);
    do_instr("illegal",   7'b1111111, 0, 0, 1'b0);
    do_instr("fetch_rdy15", T_R, TIMEOUT - 1, 0, 1'b0);
    do_instr("fetch_to",  T_R,   TIMEOUT, 0, 1'b0);
    do_instr("mem_rdy15", T_LD,  0, TIMEOUT - 1, 1'b0);
    do_instr("mem_to",    T_ST,  0, TIMEOUT, 1'b0);

    plan(T_ST, 0, 10, 1'b0, tr);
    run_steps("st_mid", 5, rc);
    do_reset("st_mid_rst");
    do_instr("after_mid_rst", T_I, 0, 0, 1'b0);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = rnd_op(); while (legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 6)];
      end
      do_instr($sformatf("rnd%0d", k), op, int'($urandom_range(0, 4)),
               int'($urandom_range(0, 4)), rnd_bit());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 15, the number of consecutive not-ready wait cycles before trapping; a value of 0 disables the timeout.
REQ-002 Port: clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 Port: rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 Port: opcode, input, 7 bits, instruction[6:0] from the instruction register; valid from the DECODE cycle.
REQ-005 Port: mem_ready, input, 1 bit, shared-memory completion strobe for the current read or write.
REQ-006 Port: br_taken, input, 1 bit, the datapath branch-comparison result; sampled only in EXEC.
REQ-007 Outputs, each 1 bit: pc_write, pc_src (0 = PC+4, 1 = target), ir_write, iord (0 = PC address, 1 = ALU address), memread, memwrite, regwrite, branch, ALUsrc, jal, retire, trap.
REQ-008 Outputs: memtoreg (2 bits: 00 ALU, 01 memory, 10 PC+4, 11 immediate), ALUop (2 bits: 00 default, 01 branch, 10 I-type, 11 R-type), state (3 bits, debug).

Function
REQ-009 The FSM SHALL have the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and TRAP=5; all other encodings SHALL go to TRAP on the next cycle.
REQ-010 In FETCH the block SHALL assert memread with iord=0.
REQ-011 In the FETCH cycle where mem_ready=1, the block SHALL assert ir_write and pc_write with pc_src=0 (Mealy) and go to DECODE; otherwise it SHALL stay in FETCH.
REQ-012 In DECODE the block SHALL latch opcode into op_q.
REQ-013 From DECODE: LUI (0110111) goes to WB.
REQ-014 From DECODE: R (0110011), I (0010011), load (0000011), store (0100011), branch (1100011) and JAL (1101111) go to EXEC.
REQ-015 From DECODE: any other opcode goes to TRAP.
REQ-016 EXEC SHALL last 1 cycle and drive the ALU controls by op_q: R gives ALUop 11, ALUsrc 0.
REQ-017 EXEC: I, load and store give ALUop 10, ALUsrc 1.
REQ-018 EXEC: branch gives ALUop 01, ALUsrc 0, branch 1.
REQ-019 EXEC: JAL gives ALUop 00, ALUsrc 0, branch 1, jal 1.
REQ-020 EXEC branch SHALL drive pc_write=br_taken with pc_src=1, then go to FETCH.
REQ-021 EXEC JAL SHALL drive pc_write=1, pc_src=1, jal=1, then go to WB.
REQ-022 EXEC transitions: load and store go to MEM; R and I go to WB.
REQ-023 MEM SHALL assert iord=1, with memread=1 for load or memwrite=1 for store, and hold them until mem_ready=1.
REQ-024 On the MEM cycle with mem_ready=1, load goes to WB and store goes to FETCH.
REQ-025 WB SHALL last 1 cycle, assert regwrite with memtoreg by op_q (R/I 00, load 01, JAL 10, LUI 11), then go to FETCH.
REQ-026 retire SHALL pulse for exactly 1 cycle on the final cycle of each instruction: WB, store MEM-with-ready, or branch EXEC.
REQ-027 wait_cnt SHALL increment on each FETCH/MEM cycle with mem_ready=0 and clear on ready or on a state change.
REQ-028 When wait_cnt reaches MEM_TIMEOUT (MEM_TIMEOUT≠0), the FSM SHALL go to TRAP.
REQ-029 mem_ready=1 in the same cycle as the timeout SHALL win and complete normally.
REQ-030 wait_cnt SHALL be wide enough for MEM_TIMEOUT and SHALL saturate rather than wrap.
REQ-031 TRAP SHALL be sticky until rst, with trap=1 and every other output 0.
REQ-032 Every output not listed for a state SHALL be 0; memwrite and regwrite SHALL never both be 1 in the same cycle.

Reset
REQ-033 rst=1 at any edge, including mid-MEM or while in TRAP, SHALL force state FETCH, op_q=0 and wait_cnt=0.
REQ-034 While rst=1, all outputs SHALL be 0, trap SHALL be 0, and state SHALL read 0.
REQ-035 The first fetch memread SHALL occur in the first cycle after rst is deasserted.

Structure
REQ-036 Package mc_pkg SHALL hold the state encodings, the 7-bit opcode constants, and the memtoreg and ALUop encodings.
REQ-037 The opcode classification (R/I/LD/ST/BR/JAL/LUI/illegal) SHALL live in one combinational sub-module, op_class, used by DECODE and by the state output logic.

Verification
REQ-038 R add with mem_ready=1: after rst, expect states FETCH→DECODE→EXEC→WB, 4 cycles; ALUop=11 in EXEC; regwrite=1 and memtoreg=00 in WB; retire once.
REQ-039 Load with 3 wait cycles in MEM: memread and iord held 4 cycles; WB memtoreg=01; 8 cycles total.
REQ-040 Branch with br_taken=0, then br_taken=1: pc_write is 0 then 1 in EXEC with pc_src=1; 3 cycles each; no regwrite.
REQ-041 JAL followed by LUI: JAL has pc_write, pc_src=1 and jal=1 in EXEC, then WB memtoreg=10; LUI is FETCH→DECODE→WB with memtoreg=11.
REQ-042 Opcode 1111111 gives TRAP after DECODE.
REQ-043 mem_ready held low 15 cycles in FETCH gives TRAP; ready arriving on the 15th cycle completes normally; rst asserted mid-MEM of a store gives memwrite=0 on the next cycle and FETCH.
